// File: rtl/n5_b2_serial_adder.sv
// Bit-serial base-2 adder: one full-adder cell plus a carry flip-flop
// produce x + y + cin one digit per clock, LSB first, with a start/busy/done
// handshake. The result (sum, carry out, two's-complement overflow) is
// held until the next accepted start.

module n5_b2_serial_adder #(
  parameter int N = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ow
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [N-1:0]  xr;
  logic [N-1:0]  yr;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          digit;
  logic          carry_out;

  // Single full-adder cell working on the current low digits and the carry.
  always_comb begin
    digit     = xr[0] ^ yr[0] ^ carry;
    carry_out = (xr[0] & yr[0]) | (xr[0] & carry) | (yr[0] & carry);
  end

  // Sequencer: accept operands, shift one digit per clock, publish result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      xr    <= '0;
      yr    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ow    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            xr    <= x;
            yr    <= y;
            carry <= cin;
            cnt   <= '0;
            s     <= '0;
            busy  <= 1'b1;
            state <= BUSY;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        BUSY: begin
          s     <= {digit, s[N-1:1]};
          carry <= carry_out;
          xr    <= xr >> 1;
          yr    <= yr >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout  <= carry_out;
            ow    <= carry ^ carry_out;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n5_b2_serial_adder.sv
// Self-checking bench for n5_b2_serial_adder: directed cases, handshake
// scenarios, reset abort and an exhaustive sweep against an arithmetic model.

module tb_n5_b2_serial_adder;

  localparam int N       = 5;
  localparam int TIMEOUT = 3 * N + 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         cout;
  logic         ow;

  int n_checks = 0;
  int n_fail   = 0;

  n5_b2_serial_adder #(.N(N)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .x(x),
    .y(y),
    .cin(cin),
    .busy(busy),
    .done(done),
    .s(s),
    .cout(cout),
    .ow(ow)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Reference: plain unsigned and signed integer addition.
  function automatic void model(input int a, input int b, input int c,
                                output logic [N-1:0] es, output logic ec,
                                output logic eo);
    int usum;
    int sa;
    int sb;
    int ssum;
    usum = a + b + c;
    es   = N'(usum % (1 << N));
    ec   = (usum >= (1 << N));
    sa   = (a >= (1 << (N - 1))) ? a - (1 << N) : a;
    sb   = (b >= (1 << (N - 1))) ? b - (1 << N) : b;
    ssum = sa + sb + c;
    eo   = (ssum > (1 << (N - 1)) - 1) || (ssum < -(1 << (N - 1)));
  endfunction

  // Launch one operation and wait (bounded) for done; optionally pokes
  // start and operands while the operation is in flight.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic c, input bit noisy,
                        output int lat, output int busy_cycles);
    x = a; y = b; cin = c; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    x = N'($urandom); y = N'($urandom); cin = 1'($urandom);
    lat = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && lat < TIMEOUT) begin
      if (busy === 1'b1) busy_cycles++;
      if (noisy) begin
        start = 1'($urandom_range(0, 1));
        x = N'($urandom); y = N'($urandom); cin = 1'($urandom);
      end
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; x = 5'b01101; y = 5'b00110; cin = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (s !== '0)      begin n_fail++; $display("[TB] FAIL reset_s: got %b expected 00000", s); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cout: got %b expected 0", cout); end
    n_checks++; if (ow !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_ow: got %b expected 0", ow); end
    start = 1'b0; reset = 1'b0;
    @(posedge clock); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_vectors();
    logic [N-1:0] va [4] = '{5'b01101, 5'b11111, 5'b10000, 5'b00000};
    logic [N-1:0] vb [4] = '{5'b00110, 5'b00001, 5'b10000, 5'b00000};
    logic         vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [N-1:0] es;
    logic         ec;
    logic         eo;
    int lat;
    int bc;
    for (int i = 0; i < 4; i++) begin
      model(int'(va[i]), int'(vb[i]), int'(vc[i]), es, ec, eo);
      run_op(va[i], vb[i], vc[i], 1'b0, lat, bc);
      n_checks++; if (lat !== N)  begin n_fail++; $display("[TB] FAIL vec%0d_latency: got %0d expected %0d", i, lat, N); end
      n_checks++; if (bc !== N)   begin n_fail++; $display("[TB] FAIL vec%0d_busy_cycles: got %0d expected %0d", i, bc, N); end
      n_checks++; if (s !== es)   begin n_fail++; $display("[TB] FAIL vec%0d_s: got %b expected %b", i, s, es); end
      n_checks++; if (cout !== ec) begin n_fail++; $display("[TB] FAIL vec%0d_cout: got %b expected %b", i, cout, ec); end
      n_checks++; if (ow !== eo)  begin n_fail++; $display("[TB] FAIL vec%0d_ow: got %b expected %b", i, ow, eo); end
      @(posedge clock); #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL vec%0d_done_pulse: got %b expected 0", i, done); end
      n_checks++; if (s !== es)   begin n_fail++; $display("[TB] FAIL vec%0d_s_hold: got %b expected %b", i, s, es); end
    end
  endtask

  task automatic test_start_during_busy();
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c;
    logic [N-1:0] es;
    logic         ec;
    logic         eo;
    int lat;
    int bc;
    for (int i = 0; i < 4; i++) begin
      a = N'($urandom); b = N'($urandom); c = 1'($urandom);
      model(int'(a), int'(b), int'(c), es, ec, eo);
      run_op(a, b, c, 1'b1, lat, bc);
      n_checks++; if (lat !== N)   begin n_fail++; $display("[TB] FAIL noisy%0d_latency: got %0d expected %0d", i, lat, N); end
      n_checks++; if (s !== es)    begin n_fail++; $display("[TB] FAIL noisy%0d_s: got %b expected %b", i, s, es); end
      n_checks++; if (cout !== ec) begin n_fail++; $display("[TB] FAIL noisy%0d_cout: got %b expected %b", i, cout, ec); end
      n_checks++; if (ow !== eo)   begin n_fail++; $display("[TB] FAIL noisy%0d_ow: got %b expected %b", i, ow, eo); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] b_x;
    logic [N-1:0] b_y;
    logic         b_c;
    logic [N-1:0] es;
    logic         ec;
    logic         eo;
    int lat;
    int bc;
    run_op(5'b10000, 5'b10000, 1'b0, 1'b0, lat, bc);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_first_done: got %b expected 1", done); end
    b_x = N'($urandom); b_y = N'($urandom); b_c = 1'($urandom);
    model(int'(b_x), int'(b_y), int'(b_c), es, ec, eo);
    x = b_x; y = b_y; cin = b_c; start = 1'b1;
    @(posedge clock); #1;
    x = ~b_x; y = ~b_y; cin = ~b_c; start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_busy: got %b expected 1", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_done_low: got %b expected 0", done); end
    n_checks++; if (s !== '0)      begin n_fail++; $display("[TB] FAIL b2b_s_clear: got %b expected 00000", s); end
    n_checks++; if (cout !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_cout_hold: got %b expected 1", cout); end
    n_checks++; if (ow !== 1'b1)   begin n_fail++; $display("[TB] FAIL b2b_ow_hold: got %b expected 1", ow); end
    lat = 0;
    while (done !== 1'b1 && lat < TIMEOUT) begin
      @(posedge clock); #1;
      lat++;
    end
    n_checks++; if (lat !== N)   begin n_fail++; $display("[TB] FAIL b2b_latency: got %0d expected %0d", lat, N); end
    n_checks++; if (s !== es)    begin n_fail++; $display("[TB] FAIL b2b_s: got %b expected %b", s, es); end
    n_checks++; if (cout !== ec) begin n_fail++; $display("[TB] FAIL b2b_cout: got %b expected %b", cout, ec); end
    n_checks++; if (ow !== eo)   begin n_fail++; $display("[TB] FAIL b2b_ow: got %b expected %b", ow, eo); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_abort();
    logic [N-1:0] es;
    logic         ec;
    logic         eo;
    int lat;
    int bc;
    int done_seen;
    run_op(5'b10111, 5'b10111, 1'b0, 1'b0, lat, bc);
    @(posedge clock); #1;
    x = 5'b11111; y = 5'b11111; cin = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    n_checks++; if (s !== '0)      begin n_fail++; $display("[TB] FAIL abort_s: got %b expected 00000", s); end
    n_checks++; if (cout !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_cout: got %b expected 0", cout); end
    n_checks++; if (ow !== 1'b0)   begin n_fail++; $display("[TB] FAIL abort_ow: got %b expected 0", ow); end
    done_seen = 0;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    n_checks++; if (done_seen !== 0) begin n_fail++; $display("[TB] FAIL abort_no_activity: got %0d expected 0", done_seen); end
    model(13, 6, 0, es, ec, eo);
    run_op(5'b01101, 5'b00110, 1'b0, 1'b0, lat, bc);
    n_checks++; if (lat !== N)   begin n_fail++; $display("[TB] FAIL abort_fresh_latency: got %0d expected %0d", lat, N); end
    n_checks++; if (s !== es)    begin n_fail++; $display("[TB] FAIL abort_fresh_s: got %b expected %b", s, es); end
    n_checks++; if (cout !== ec) begin n_fail++; $display("[TB] FAIL abort_fresh_cout: got %b expected %b", cout, ec); end
    n_checks++; if (ow !== eo)   begin n_fail++; $display("[TB] FAIL abort_fresh_ow: got %b expected %b", ow, eo); end
    @(posedge clock); #1;
  endtask

  task automatic test_exhaustive();
    logic [N-1:0] es;
    logic         ec;
    logic         eo;
    int lat;
    int bc;
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < (1 << N); a++) begin
        for (int b = 0; b < (1 << N); b++) begin
          model(a, b, c, es, ec, eo);
          run_op(N'(a), N'(b), 1'(c), 1'b0, lat, bc);
          n_checks++; if (lat !== N)   begin n_fail++; $display("[TB] FAIL sweep_latency %0d+%0d+%0d: got %0d expected %0d", a, b, c, lat, N); end
          n_checks++; if (s !== es)    begin n_fail++; $display("[TB] FAIL sweep_s %0d+%0d+%0d: got %b expected %b", a, b, c, s, es); end
          n_checks++; if (cout !== ec) begin n_fail++; $display("[TB] FAIL sweep_cout %0d+%0d+%0d: got %b expected %b", a, b, c, cout, ec); end
          n_checks++; if (ow !== eo)   begin n_fail++; $display("[TB] FAIL sweep_ow %0d+%0d+%0d: got %b expected %b", a, b, c, ow, eo); end
        end
      end
    end
    @(posedge clock); #1;
  endtask

  // Test sequence.
  initial begin
    reset = 1'b1; start = 1'b0; x = '0; y = '0; cin = 1'b0;
    test_reset();
    test_vectors();
    test_start_during_busy();
    test_back_to_back();
    test_reset_abort();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
